icache: RTL and testbench
=========================

ICACHE -- requirements
Module: icache

Interface
REQ-001 Parameter INDEX_W, default 6, index bits; the SHALL hold 2^INDEX_W lines of 8 bytes (two instructions) each.
REQ-002 clk_in  input  1  system clock; all state SHALL update on its rising edge.
REQ-003 rst_in  input  1  reset, synchronous, active-high.
REQ-004 rdy_in  input  1  pause; when low, all state and outputs SHALL hold.
REQ-005 clear_signal  input  1  misprediction flush.
REQ-006 fetch_req  input  1  fetch unit requests the instruction at fetch_pc.
REQ-007 fetch_pc  input  32  instruction address, bits [1:0] = 00.
REQ-008 fetch_hit  output  1  the fetch_instr value is valid this cycle.
REQ-009 fetch_instr  output  32  instruction word for fetch_pc.
REQ-010 instr_signal  output  1  line-fill request to the memory controller.
REQ-011 instr_a  output  32  line address, {pc[31:3],3'b000}.
REQ-012 instr_d  input  64  filled line, byte 0 in [7:0].
REQ-013 instr_done  input  1  one-cycle pulse; instr_d is valid in the same cycle.

Function
REQ-014 Address split: offset pc[2:0], word select pc[2], index pc[INDEX_W+2:3], tag pc[31:INDEX_W+3].
REQ-015 Line storage: valid bit, tag and 64-bit data per line; direct-mapped.
REQ-016 Hit path, combinational: fetch_hit = fetch_req & state==IDLE & valid[idx] & tag match.
REQ-017 Word select: fetch_instr = data[idx][31:0] when pc[2]=0, data[idx][63:32] when pc[2]=1.
REQ-018 fetch_instr value when fetch_hit=0: don't-care.
REQ-019 FSM states: IDLE, MISS.
REQ-020 IDLE -> MISS: fetch_req & ~fetch_hit & ~clear_signal; latch miss line address into instr_a and set instr_signal=1 in the same edge.
REQ-021 In MISS: instr_signal SHALL stay 1 and instr_a SHALL stay constant until instr_done or clear_signal.
REQ-022 MISS, instr_done=1 & ~clear_signal: write instr_d, latched tag and valid=1 into the line indexed by instr_a; drop instr_signal; go to IDLE.
REQ-023 After a fill, a fetch_pc unchanged since the miss SHALL hit in the first IDLE cycle, so miss latency = fill time + 1 cycle.
REQ-024 MISS, clear_signal=1: drop instr_signal; go to IDLE; discard any instr_done seen in that cycle; no line is written.
REQ-025 instr_done SHALL be ignored in IDLE.
REQ-026 clear_signal SHALL NOT invalidate lines.
REQ-027 A new miss MAY be raised in the cycle after a fill; the controller serves it once its done pulse has cleared.
REQ-028 fetch_pc changing during MISS SHALL NOT alter instr_a; the fill completes, and the new pc is evaluated in IDLE.
REQ-029 rdy_in=0: no state, array or output register SHALL change, including while in MISS.

Reset
REQ-030 rst_in=1 (precedence over rdy_in): state=IDLE, instr_signal=0, instr_a=0, all valid bits 0; the tag and data arrays need not be cleared.
REQ-031 Reset while in MISS SHALL abandon the fill; the controller is reset by the same signal.

Structure
REQ-032 A shared package SHALL hold the state encoding and the LINE_BYTES=8 constant.
REQ-033 No sub-module; the arrays SHALL be plain register arrays inferred in this module.

Verification
REQ-034 Cold miss: reset, fetch_req=1, fetch_pc=0x0000_1004 -> instr_signal=1 and instr_a=0x0000_1000 next cycle; on instr_done with instr_d=0x11223344_55667788 -> fetch_hit=1 and fetch_instr=0x11223344 the following cycle.
REQ-035 Same-line hit: after REQ-034, fetch_pc=0x0000_1000 -> fetch_hit=1 the same cycle, fetch_instr=0x55667788, instr_signal stays 0.
REQ-036 Conflict eviction (INDEX_W=6): fill 0x0000_1000, then fetch 0x0000_1200 -> miss and refill; then fetch 0x0000_1000 -> miss again.
REQ-037 Flush mid-miss: clear_signal=1 two cycles into MISS -> instr_signal=0 next cycle, state IDLE, line stays invalid; an instr_done in the clear cycle is ignored.
REQ-038 Pause: rdy_in=0 for 5 cycles during MISS -> instr_a and instr_signal unchanged; fill completes normally after rdy_in returns to 1.
REQ-039 Reset after fills: rst_in=1 -> a previously hit address misses.

Source files
------------

// File: rtl/icache_pkg.sv
// icache_pkg: shared FSM encoding and line geometry for the instruction cache.
package icache_pkg;
    typedef enum logic {IDLE, MISS} state_t;
    localparam int LINE_BYTES = 8;
endpackage

// File: rtl/icache_if.sv
// icache_if: fetch-side and memory-controller-side signals of the instruction cache.
interface icache_if;
    logic        fetch_req;
    logic [31:0] fetch_pc;
    logic        fetch_hit;
    logic [31:0] fetch_instr;
    logic        instr_signal;
    logic [31:0] instr_a;
    logic [63:0] instr_d;
    logic        instr_done;
    modport master (
        output fetch_req, fetch_pc, instr_d, instr_done,
        input  fetch_hit, fetch_instr, instr_signal, instr_a
    );
    modport slave (
        input  fetch_req, fetch_pc, instr_d, instr_done,
        output fetch_hit, fetch_instr, instr_signal, instr_a
    );
endinterface

// File: rtl/icache.sv
// icache: direct-mapped instruction cache with 8-byte lines and a single outstanding fill.
module icache
    import icache_pkg::*;
#(
    parameter int INDEX_W = 6
) (
    input logic   clk_in,
    input logic   rst_in,
    input logic   rdy_in,
    input logic   clear_signal,
    icache_if.slave bus
);
    localparam int OFF_W = $clog2(LINE_BYTES);
    localparam int TAG_W = 32 - INDEX_W - OFF_W;
    localparam int LINES = 1 << INDEX_W;

    logic [LINES-1:0]   valid;
    logic [TAG_W-1:0]   tags [LINES];
    logic [63:0]        data [LINES];
    state_t             state, state_n;
    logic [INDEX_W-1:0] idx, fill_idx;
    logic [TAG_W-1:0]   tag, fill_tag;
    logic               miss_start, fill;

    assign idx      = bus.fetch_pc[INDEX_W+OFF_W-1:OFF_W];
    assign tag      = bus.fetch_pc[31:INDEX_W+OFF_W];
    // The latched line address doubles as the fill index and tag.
    assign fill_idx = bus.instr_a[INDEX_W+OFF_W-1:OFF_W];
    assign fill_tag = bus.instr_a[31:INDEX_W+OFF_W];

    assign bus.fetch_hit   = bus.fetch_req && state == IDLE && valid[idx] && tags[idx] == tag;
    assign bus.fetch_instr = bus.fetch_pc[2] ? data[idx][63:32] : data[idx][31:0];

    always_comb begin
        miss_start = 1'b0;
        fill       = 1'b0;
        state_n    = state;
        miss_start = state == IDLE && bus.fetch_req && !bus.fetch_hit && !clear_signal;
        fill       = state == MISS && bus.instr_done && !clear_signal;
        state_n    = state == IDLE ? (miss_start ? MISS : IDLE)
                                   : ((bus.instr_done || clear_signal) ? IDLE : MISS);
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) state <= IDLE;
        else if (rdy_in) state <= state_n;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            bus.instr_signal <= 1'b0;
            bus.instr_a      <= '0;
            valid            <= '0;
        end else if (rdy_in) begin
            bus.instr_signal <= state_n == MISS;
            if (miss_start) bus.instr_a <= {bus.fetch_pc[31:OFF_W], {OFF_W{1'b0}}};
            if (fill) valid[fill_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in && rdy_in && fill) begin
            tags[fill_idx] <= fill_tag;
            data[fill_idx] <= bus.instr_d;
        end
    end
endmodule

// File: tb/tb_icache.sv
// tb_icache: directed scenario tests for the instruction cache.
`timescale 1ns/1ps
module tb_icache;
    logic clk = 1'b0;
    logic rst, rdy, clear;
    int   checks = 0;
    int   errors = 0;

    icache_if bus ();

    icache #(.INDEX_W(6)) dut (
        .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .clear_signal(clear), .bus(bus.slave)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; rdy = 1'b0; clear = 1'b0;
        bus.fetch_req = 1'b1; bus.fetch_pc = 32'h0000_1004;
        bus.instr_d = '0; bus.instr_done = 1'b0;
        step(); step();
        checks++;
        if (bus.instr_signal !== 1'b0) begin errors++; $display("FAIL reset_signal got %b want 0", bus.instr_signal); end
        checks++;
        if (bus.instr_a !== 32'h0) begin errors++; $display("FAIL reset_addr got %h want 0", bus.instr_a); end
        checks++;
        if (bus.fetch_hit !== 1'b0) begin errors++; $display("FAIL reset_hit got %b want 0", bus.fetch_hit); end
        bus.fetch_req = 1'b0; rdy = 1'b1;
        step();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_cold_miss();
        bus.fetch_req = 1'b1; bus.fetch_pc = 32'h0000_1004;
        #1;
        checks++;
        if (bus.fetch_hit !== 1'b0) begin errors++; $display("FAIL cold_hit_before got %b want 0", bus.fetch_hit); end
        step();
        checks++;
        if (bus.instr_signal !== 1'b1) begin errors++; $display("FAIL cold_signal got %b want 1", bus.instr_signal); end
        checks++;
        if (bus.instr_a !== 32'h0000_1000) begin errors++; $display("FAIL cold_addr got %h want 00001000", bus.instr_a); end
        step(); step();
        checks++;
        if (bus.instr_signal !== 1'b1 || bus.instr_a !== 32'h0000_1000) begin
            errors++; $display("FAIL cold_hold got %b/%h want 1/00001000", bus.instr_signal, bus.instr_a);
        end
        bus.instr_done = 1'b1; bus.instr_d = 64'h11223344_55667788;
        #1;
        checks++;
        if (bus.fetch_hit !== 1'b0) begin errors++; $display("FAIL cold_hit_in_miss got %b want 0", bus.fetch_hit); end
        step();
        bus.instr_done = 1'b0;
        #1;
        checks++;
        if (bus.fetch_hit !== 1'b1 || bus.fetch_instr !== 32'h11223344) begin
            errors++; $display("FAIL cold_fill_hit got %b/%h want 1/11223344", bus.fetch_hit, bus.fetch_instr);
        end
        checks++;
        if (bus.instr_signal !== 1'b0) begin errors++; $display("FAIL cold_drop got %b want 0", bus.instr_signal); end
        bus.instr_done = 1'b1; bus.instr_d = 64'hDEADBEEF_DEADBEEF;
        step();
        bus.instr_done = 1'b0;
        #1;
        checks++;
        if (bus.fetch_hit !== 1'b1 || bus.fetch_instr !== 32'h11223344) begin
            errors++; $display("FAIL idle_done_ignored got %b/%h want 1/11223344", bus.fetch_hit, bus.fetch_instr);
        end
    endtask

    task automatic test_same_line();
        bus.fetch_pc = 32'h0000_1000;
        #1;
        checks++;
        if (bus.fetch_hit !== 1'b1 || bus.fetch_instr !== 32'h55667788) begin
            errors++; $display("FAIL same_line got %b/%h want 1/55667788", bus.fetch_hit, bus.fetch_instr);
        end
        step();
        checks++;
        if (bus.instr_signal !== 1'b0) begin errors++; $display("FAIL same_line_signal got %b want 0", bus.instr_signal); end
    endtask

    task automatic test_conflict();
        bus.fetch_pc = 32'h0000_1200;
        #1;
        checks++;
        if (bus.fetch_hit !== 1'b0) begin errors++; $display("FAIL conflict_hit got %b want 0", bus.fetch_hit); end
        step();
        checks++;
        if (bus.instr_signal !== 1'b1 || bus.instr_a !== 32'h0000_1200) begin
            errors++; $display("FAIL conflict_req got %b/%h want 1/00001200", bus.instr_signal, bus.instr_a);
        end
        bus.instr_done = 1'b1; bus.instr_d = 64'hAAAA0001_BBBB0002;
        step();
        bus.instr_done = 1'b0;
        #1;
        checks++;
        if (bus.fetch_hit !== 1'b1 || bus.fetch_instr !== 32'hBBBB0002) begin
            errors++; $display("FAIL conflict_fill got %b/%h want 1/bbbb0002", bus.fetch_hit, bus.fetch_instr);
        end
        bus.fetch_pc = 32'h0000_1000;
        #1;
        checks++;
        if (bus.fetch_hit !== 1'b0) begin errors++; $display("FAIL evicted_hit got %b want 0", bus.fetch_hit); end
        step();
        checks++;
        if (bus.instr_signal !== 1'b1 || bus.instr_a !== 32'h0000_1000) begin
            errors++; $display("FAIL evicted_req got %b/%h want 1/00001000", bus.instr_signal, bus.instr_a);
        end
        bus.instr_done = 1'b1; bus.instr_d = 64'h11223344_55667788;
        step();
        bus.instr_done = 1'b0;
        #1;
        checks++;
        if (bus.fetch_hit !== 1'b1 || bus.fetch_instr !== 32'h55667788) begin
            errors++; $display("FAIL refill got %b/%h want 1/55667788", bus.fetch_hit, bus.fetch_instr);
        end
    endtask

    task automatic test_flush();
        bus.fetch_pc = 32'h0000_2008;
        step();
        checks++;
        if (bus.instr_signal !== 1'b1 || bus.instr_a !== 32'h0000_2008) begin
            errors++; $display("FAIL flush_req got %b/%h want 1/00002008", bus.instr_signal, bus.instr_a);
        end
        step(); step();
        clear = 1'b1; bus.instr_done = 1'b1; bus.instr_d = 64'h99999999_88888888;
        step();
        clear = 1'b0; bus.instr_done = 1'b0;
        #1;
        checks++;
        if (bus.instr_signal !== 1'b0) begin errors++; $display("FAIL flush_drop got %b want 0", bus.instr_signal); end
        checks++;
        if (bus.fetch_hit !== 1'b0) begin errors++; $display("FAIL flush_line_written got %b want 0", bus.fetch_hit); end
        bus.fetch_pc = 32'h0000_1004;
        #1;
        checks++;
        if (bus.fetch_hit !== 1'b1 || bus.fetch_instr !== 32'h11223344) begin
            errors++; $display("FAIL flush_kept_line got %b/%h want 1/11223344", bus.fetch_hit, bus.fetch_instr);
        end
        step();
        checks++;
        if (bus.instr_signal !== 1'b0) begin errors++; $display("FAIL flush_idle got %b want 0", bus.instr_signal); end
    endtask

    task automatic test_pause();
        bus.fetch_pc = 32'h0000_3014;
        step();
        checks++;
        if (bus.instr_signal !== 1'b1 || bus.instr_a !== 32'h0000_3010) begin
            errors++; $display("FAIL pause_req got %b/%h want 1/00003010", bus.instr_signal, bus.instr_a);
        end
        rdy = 1'b0; bus.fetch_pc = 32'h0000_4000;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (bus.instr_signal !== 1'b1 || bus.instr_a !== 32'h0000_3010) begin
                errors++; $display("FAIL pause_hold[%0d] got %b/%h want 1/00003010", i, bus.instr_signal, bus.instr_a);
            end
        end
        rdy = 1'b1;
        step();
        checks++;
        if (bus.instr_signal !== 1'b1 || bus.instr_a !== 32'h0000_3010) begin
            errors++; $display("FAIL pause_pc_change got %b/%h want 1/00003010", bus.instr_signal, bus.instr_a);
        end
        bus.instr_done = 1'b1; bus.instr_d = 64'hCAFEF00D_12345678;
        bus.fetch_pc = 32'h0000_3014;
        step();
        bus.instr_done = 1'b0;
        #1;
        checks++;
        if (bus.fetch_hit !== 1'b1 || bus.fetch_instr !== 32'hCAFEF00D) begin
            errors++; $display("FAIL pause_fill got %b/%h want 1/cafef00d", bus.fetch_hit, bus.fetch_instr);
        end
    endtask

    task automatic test_reset_after_fill();
        bus.fetch_pc = 32'h0000_1000;
        #1;
        checks++;
        if (bus.fetch_hit !== 1'b1) begin errors++; $display("FAIL pre_reset_hit got %b want 1", bus.fetch_hit); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        checks++;
        if (bus.fetch_hit !== 1'b0 || bus.instr_signal !== 1'b0) begin
            errors++; $display("FAIL post_reset got %b/%b want 0/0", bus.fetch_hit, bus.instr_signal);
        end
        step();
        checks++;
        if (bus.instr_signal !== 1'b1 || bus.instr_a !== 32'h0000_1000) begin
            errors++; $display("FAIL post_reset_miss got %b/%h want 1/00001000", bus.instr_signal, bus.instr_a);
        end
        bus.fetch_req = 1'b0;
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_same_line();
        test_conflict();
        test_flush();
        test_pause();
        test_reset_after_fill();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
